// File: rtl/main_fifo_umbral.sv
// main_fifo_umbral
//   Main ingress FIFO of the D0/D1 packet path. Stores up to LENGTH words from
//   the source and feeds the VC demux stage. Main_pause is raised when the free
//   space drops to or below a programmable threshold latched on init. Overflow
//   (push while full with no pop) drops the word and sets a sticky error.
//
// Optional feature macro: MAIN_FIFO_FWFT_EN
//   defined   : first-word-fall-through. data_out shows the head word
//               combinationally, valid_out = !empty, pop consumes it.
//   undefined : registered read. data_out/valid_out update on the edge after
//               an accepted pop; valid_out pulses for one cycle per pop.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   init         in   strobe: latch min(Umbral_MF, LENGTH-1) as threshold
//   Umbral_MF    in   [3:0] almost-full / almost-empty threshold
//   push         in   write request
//   data_in      in   [BITNUMBER-1:0] write data
//   pop          in   read request
//   data_out     out  [BITNUMBER-1:0] read data
//   valid_out    out  data_out holds a popped word
//   Main_pause   out  (LENGTH - count) <= threshold
//   almost_empty out  count <= threshold
//   full         out  count == LENGTH
//   empty        out  count == 0
//   error        out  sticky overflow flag, cleared only by reset
module main_fifo_umbral #(
  parameter int unsigned BITNUMBER = 6,
  parameter int unsigned LENGTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [3:0]           Umbral_MF,
  input  logic                 push,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 pop,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  output logic                 Main_pause,
  output logic                 almost_empty,
  output logic                 full,
  output logic                 empty,
  output logic                 error
);

  localparam int unsigned PtrW = $clog2(LENGTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(LENGTH);

  // Largest threshold representable on the 4-bit input that is also <= LENGTH-1.
  localparam int unsigned ThrMaxInt = (LENGTH - 1 > 15) ? 15 : LENGTH - 1;
  localparam logic [3:0]  ThrMax    = 4'(ThrMaxInt);

  logic [BITNUMBER-1:0] r_mem [LENGTH];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic [3:0]           r_thr;
  logic                 r_error;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_rd_en;
  logic                 w_wr_en;
  logic                 w_overflow;
  logic [3:0]           w_thr_clamped;
  logic [31:0]          w_free;
  logic [31:0]          w_count_ext;
  logic [31:0]          w_thr_ext;

  assign w_full  = (r_count == CntFull);
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same cycle, so push while full is accepted if
  // a pop is also accepted.
  assign w_rd_en    = pop && !w_empty;
  assign w_wr_en    = push && (!w_full || w_rd_en);
  assign w_overflow = push && w_full && !pop;

  assign w_thr_clamped = (Umbral_MF > ThrMax) ? ThrMax : Umbral_MF;

  // Memory is deliberately not reset; writes are suppressed while in reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_thr    <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      unique case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
      if (init) begin
        r_thr <= w_thr_clamped;
      end
      if (w_overflow) begin
        r_error <= 1'b1;
      end
    end
  end

  // Threshold compares done on 32-bit values so no width juggling is needed
  // for any LENGTH; count never exceeds LENGTH so the subtraction cannot wrap.
  assign w_count_ext = 32'(r_count);
  assign w_thr_ext   = 32'(r_thr);
  assign w_free      = LENGTH - w_count_ext;

  assign Main_pause   = (w_free <= w_thr_ext);
  assign almost_empty = (w_count_ext <= w_thr_ext);
  assign full         = w_full;
  assign empty        = w_empty;
  assign error        = r_error;

`ifdef MAIN_FIFO_FWFT_EN
  // Head word falls through; forced to zero when empty so stale memory never shows.
  assign data_out  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign valid_out = !w_empty;
`else
  logic [BITNUMBER-1:0] r_data_out;
  logic                 r_valid_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_rd_en;
      if (w_rd_en) begin
        r_data_out <= r_mem[r_rd_ptr];
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
`endif

endmodule

// File: tb/tb_main_fifo_umbral.sv
// Testbench for main_fifo_umbral: directed scenarios followed by random
// traffic, checked against a queue-based reference model and a scoreboard of
// expected read words.
module tb_main_fifo_umbral;

  localparam int unsigned BW  = 6;
  localparam int unsigned LEN = 4;

  logic          clk;
  logic          reset;
  logic          init;
  logic [3:0]    Umbral_MF;
  logic          push;
  logic [BW-1:0] data_in;
  logic          pop;
  logic [BW-1:0] data_out;
  logic          valid_out;
  logic          Main_pause;
  logic          almost_empty;
  logic          full;
  logic          empty;
  logic          error;

  main_fifo_umbral #(
    .BITNUMBER(BW),
    .LENGTH   (LEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .Umbral_MF   (Umbral_MF),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .Main_pause  (Main_pause),
    .almost_empty(almost_empty),
    .full        (full),
    .empty       (empty),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [BW-1:0] m_q[$];
  logic [BW-1:0] exp_q[$];
  int            m_thr;
  bit            m_err;
  bit            m_valid;
  logic [BW-1:0] m_last;
  bit            started;

  int n_checks;
  int n_pass;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic void model_step(input bit rs, input bit ini, input int u, input bit ps,
                                     input logic [BW-1:0] d, input bit pp);
    bit            acc_pop;
    bit            was_full;
    logic [BW-1:0] w;
    if (rs) begin
      m_q.delete();
      exp_q.delete();
      m_thr   = 0;
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_last  = '0;
      return;
    end
    was_full = (m_q.size() == LEN);
    acc_pop  = pp && (m_q.size() > 0);
    if (ps && was_full && !pp) m_err = 1'b1;
    m_valid = acc_pop;
    if (acc_pop) begin
      w = m_q.pop_front();
      m_last = w;
`ifndef MAIN_FIFO_FWFT_EN
      exp_q.push_back(w);
`endif
    end
    if (ps && (!was_full || acc_pop)) m_q.push_back(d);
    if (ini) m_thr = (u > int'(LEN) - 1) ? int'(LEN) - 1 : u;
  endfunction

  task automatic drive(input bit rs, input bit ini, input int u, input bit ps,
                       input logic [BW-1:0] d, input bit pp);
    reset     = rs;
    init      = ini;
    Umbral_MF = 4'(u);
    push      = ps;
    data_in   = d;
    pop       = pp;
    @(posedge clk);
    model_step(rs, ini, u, ps, d, pp);
    started = 1'b1;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, 0);
  endtask

  // Monitor: compares flags every cycle and retires scoreboard entries on valid_out.
  always @(negedge clk) begin
    if (started) begin
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("full", 32'(full), 32'(m_q.size() == LEN));
      check("almost_empty", 32'(almost_empty), 32'(m_q.size() <= m_thr));
      check("Main_pause", 32'(Main_pause), 32'((int'(LEN) - m_q.size()) <= m_thr));
      check("error", 32'(error), 32'(m_err));
`ifdef MAIN_FIFO_FWFT_EN
      check("valid_out", 32'(valid_out), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("fwft_head", 32'(data_out), 32'(m_q[0]));
`else
      check("valid_out", 32'(valid_out), 32'(m_valid));
      check("data_hold", 32'(data_out), 32'(m_last));
      if (valid_out) begin
        if (exp_q.size() == 0) check("unexpected_valid", 32'(1), 32'(0));
        else check("read_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
`endif
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    started  = 1'b0;
    reset = 1'b1; init = 1'b0; Umbral_MF = '0; push = 1'b0; data_in = '0; pop = 1'b0;

    // 1: reset
    drive(1, 0, 0, 0, '0, 0);
    drive(1, 0, 0, 0, '0, 0);
    // 2: threshold 1, fill
    drive(0, 1, 1, 0, '0, 0);
    drive(0, 0, 0, 1, 6'h01, 0);
    drive(0, 0, 0, 1, 6'h10, 0);
    drive(0, 0, 0, 1, 6'h02, 0);
    drive(0, 0, 0, 1, 6'h12, 0);
    // 3: overflow then drain
    drive(0, 0, 0, 1, 6'h3F, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, '0, 1);
    idle();
    // 4: simultaneous push/pop while full
    drive(1, 0, 0, 0, '0, 0);
    drive(0, 1, 1, 1, 6'h01, 0);
    drive(0, 0, 0, 1, 6'h10, 0);
    drive(0, 0, 0, 1, 6'h02, 0);
    drive(0, 0, 0, 1, 6'h12, 0);
    drive(0, 0, 0, 1, 6'h3E, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, '0, 1);
    idle();
    // 5: single-entry pop, pop on empty, push+pop on empty
    drive(0, 0, 0, 1, 6'h2A, 0);
    drive(0, 0, 0, 0, '0, 1);
    idle();
    drive(0, 0, 0, 0, '0, 1);
    drive(0, 0, 0, 1, 6'h15, 1);
    drive(0, 0, 0, 0, '0, 1);
    idle();
    // 6: clamped threshold, reset mid-fill
    drive(0, 1, 9, 0, '0, 0);
    drive(0, 0, 0, 1, 6'h05, 0);
    drive(0, 0, 0, 1, 6'h06, 0);
    drive(1, 0, 0, 1, 6'h07, 0);
    idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 149) == 0),
            ($urandom_range(0, 19) == 0),
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 60),
            BW'($urandom),
            ($urandom_range(0, 99) < 50));
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
